config_loader: RTL

- Serial-to-parallel configuration front end that sits directly upstream of the tile array.
- Deserialises an MSB-first bitstream into (address, data) write pairs.
- Drives the shared config_addr/config_data bus consumed by every tile.
- Tiles have no write strobe and decode the address only, so the bus rests at an idle address of zero. Upper half zero never selects a sub-block (4/5/6).

---
 rtl/config_loader_pkg.sv | 28 ++
 rtl/sipo_shift_reg.sv | 37 +++
 rtl/config_loader.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/config_loader_pkg.sv
// Shared constants for the configuration loader: FSM encodings, default widths,
// the idle bus address and the tile sub-block select codes.
package config_loader_pkg;

    localparam int CFG_ADDR_W = 32;
    localparam int CFG_DATA_W = 32;
    localparam int CFG_CNT_W  = 16;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_HDR   = 3'd1;
    localparam logic [2:0] ST_ADDR  = 3'd2;
    localparam logic [2:0] ST_DATA  = 3'd3;
    localparam logic [2:0] ST_PAR   = 3'd4;
    localparam logic [2:0] ST_ISSUE = 3'd5;
    localparam logic [2:0] ST_DONE  = 3'd6;

    // Tiles decode the address only; an upper half of zero never selects a sub-block.
    localparam logic [31:0] IDLE_CONFIG_ADDR = 32'h0000_0000;

    localparam logic [15:0] CB0 = 16'd4;
    localparam logic [15:0] CB1 = 16'd5;
    localparam logic [15:0] SB  = 16'd6;

    function automatic logic is_shift_state(input logic [2:0] st);
        return (st == ST_HDR) || (st == ST_ADDR) || (st == ST_DATA) || (st == ST_PAR);
    endfunction

endpackage

// File: rtl/sipo_shift_reg.sv
// MSB-first serial-in parallel-out register. q_next is the value the register
// holds after the current edge, so a caller can use a field the cycle it completes.
module sipo_shift_reg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         shift_en,
    input  logic         bit_in,
    output logic [W-1:0] q_next
);

    logic [W-1:0] q_r;

    // Next contents: clear wins over shift.
    always_comb begin
        q_next = q_r;
        if (clr) begin
            q_next = {W{1'b0}};
        end else if (shift_en) begin
            q_next = {q_r[W-2:0], bit_in};
        end else begin
            q_next = q_r;
        end
    end

    // Shift register storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_r <= {W{1'b0}};
        end else begin
            q_r <= q_next;
        end
    end

endmodule

// File: rtl/config_loader.sv
// Serial bitstream to (address, data) config bus writer for the tile array.
// Optional per-frame even parity is enabled with `define CONFIG_PARITY_EN.
module config_loader
    import config_loader_pkg::*;
#(
    parameter int ADDR_W = CFG_ADDR_W,
    parameter int DATA_W = CFG_DATA_W,
    parameter int CNT_W  = CFG_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              bit_in,
    input  logic              bit_valid,
    output logic              bit_ready,
    output logic [ADDR_W-1:0] config_addr,
    output logic [DATA_W-1:0] config_data,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  words_written,
    output logic              error
);

    localparam int MAX_W = (CNT_W > ADDR_W) ? ((CNT_W > DATA_W) ? CNT_W : DATA_W)
                                             : ((ADDR_W > DATA_W) ? ADDR_W : DATA_W);
    localparam int BC_W  = $clog2(MAX_W + 1);

    localparam logic [BC_W-1:0]   BC_ZERO   = {BC_W{1'b0}};
    localparam logic [BC_W-1:0]   BC_ONE    = {{(BC_W-1){1'b0}}, 1'b1};
    localparam logic [BC_W-1:0]   HDR_LAST  = BC_W'(CNT_W - 1);
    localparam logic [BC_W-1:0]   ADDR_LAST = BC_W'(ADDR_W - 1);
    localparam logic [BC_W-1:0]   DATA_LAST = BC_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [ADDR_W-1:0] IDLE_ADDR = ADDR_W'(IDLE_CONFIG_ADDR);
    localparam logic [DATA_W-1:0] IDLE_DATA = {DATA_W{1'b0}};

    logic [2:0]        state_r;
    logic [2:0]        state_nx_s;
    logic [BC_W-1:0]   bc_r;
    logic [CNT_W-1:0]  rem_r;
    logic [CNT_W-1:0]  ww_r;
    logic [ADDR_W-1:0] config_addr_r;
    logic [DATA_W-1:0] config_data_r;
    logic              bit_ready_r;
    logic              busy_r;
    logic              done_r;
    logic              accept_s;
    logic              start_s;
    logic              field_last_s;
    logic [CNT_W-1:0]  hdr_s;
    logic [ADDR_W-1:0] addr_s;
    logic [DATA_W-1:0] data_s;

    assign accept_s = bit_valid & bit_ready_r;
    assign start_s  = (state_r == ST_IDLE) & load_start;

    sipo_shift_reg #(.W(CNT_W)) u_hdr (
        .clk(clk), .rst(rst), .clr(start_s),
        .shift_en((state_r == ST_HDR) & accept_s), .bit_in(bit_in), .q_next(hdr_s)
    );

    sipo_shift_reg #(.W(ADDR_W)) u_addr (
        .clk(clk), .rst(rst), .clr(start_s),
        .shift_en((state_r == ST_ADDR) & accept_s), .bit_in(bit_in), .q_next(addr_s)
    );

    sipo_shift_reg #(.W(DATA_W)) u_data (
        .clk(clk), .rst(rst), .clr(start_s),
        .shift_en((state_r == ST_DATA) & accept_s), .bit_in(bit_in), .q_next(data_s)
    );

`ifdef CONFIG_PARITY_EN
    logic par_ok_s;
    logic error_r;

    function automatic logic even_parity(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        return ^{a, d};
    endfunction

    assign par_ok_s = (even_parity(addr_s, data_s) == bit_in);
`endif

    // Last bit of the field currently being shifted in; the parity field is one bit.
    always_comb begin
        field_last_s = 1'b0;
        case (state_r)
            ST_HDR:  field_last_s = (bc_r == HDR_LAST);
            ST_ADDR: field_last_s = (bc_r == ADDR_LAST);
            ST_DATA: field_last_s = (bc_r == DATA_LAST);
            default: field_last_s = 1'b1;
        endcase
    end

    // Next-state decode.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (load_start) state_nx_s = ST_HDR;
                else            state_nx_s = ST_IDLE;
            end
            ST_HDR: begin
                if (accept_s && field_last_s) begin
                    if (hdr_s == CNT_ZERO) state_nx_s = ST_DONE;
                    else                   state_nx_s = ST_ADDR;
                end else begin
                    state_nx_s = ST_HDR;
                end
            end
            ST_ADDR: begin
                if (accept_s && field_last_s) state_nx_s = ST_DATA;
                else                          state_nx_s = ST_ADDR;
            end
            ST_DATA: begin
                if (accept_s && field_last_s) begin
`ifdef CONFIG_PARITY_EN
                    state_nx_s = ST_PAR;
`else
                    state_nx_s = ST_ISSUE;
`endif
                end else begin
                    state_nx_s = ST_DATA;
                end
            end
`ifdef CONFIG_PARITY_EN
            ST_PAR: begin
                if (accept_s) begin
                    if (par_ok_s)              state_nx_s = ST_ISSUE;
                    else if (rem_r == CNT_ONE) state_nx_s = ST_DONE;
                    else                       state_nx_s = ST_ADDR;
                end else begin
                    state_nx_s = ST_PAR;
                end
            end
`endif
            ST_ISSUE: begin
                if (rem_r == CNT_ONE) state_nx_s = ST_DONE;
                else                  state_nx_s = ST_ADDR;
            end
            ST_DONE: state_nx_s = ST_IDLE;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // State register and per-field bit counter, restarted on every state change.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            bc_r    <= BC_ZERO;
        end else begin
            state_r <= state_nx_s;
            if (state_nx_s != state_r) bc_r <= BC_ZERO;
            else if (accept_s)         bc_r <= bc_r + BC_ONE;
        end
    end

    // Frames remaining; loaded from the header and only decremented while above one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem_r <= CNT_ZERO;
        end else if ((state_r == ST_HDR) && (state_nx_s != ST_HDR)) begin
            rem_r <= hdr_s;
        end else if (((state_r == ST_ISSUE) || (state_r == ST_PAR)) && (state_nx_s == ST_ADDR)) begin
            rem_r <= rem_r - CNT_ONE;
        end
    end

    // Registered outputs decoded from the next state so they align with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            config_addr_r <= IDLE_ADDR;
            config_data_r <= IDLE_DATA;
            bit_ready_r   <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            ww_r          <= CNT_ZERO;
        end else begin
            bit_ready_r <= is_shift_state(state_nx_s);
            busy_r      <= (state_nx_s != ST_IDLE) && (state_nx_s != ST_DONE);
            if (state_nx_s == ST_ISSUE) begin
                config_addr_r <= addr_s;
                config_data_r <= data_s;
            end else begin
                config_addr_r <= IDLE_ADDR;
                config_data_r <= IDLE_DATA;
            end
            if (start_s)                      done_r <= 1'b0;
            else if (state_nx_s == ST_DONE)   done_r <= 1'b1;
            if (start_s)                                      ww_r <= CNT_ZERO;
            else if ((state_nx_s == ST_ISSUE) && (ww_r != CNT_MAX)) ww_r <= ww_r + CNT_ONE;
        end
    end

`ifdef CONFIG_PARITY_EN
    // Sticky parity error, cleared only by an accepted load_start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            error_r <= 1'b0;
        end else if (start_s) begin
            error_r <= 1'b0;
        end else if ((state_r == ST_PAR) && accept_s && !par_ok_s) begin
            error_r <= 1'b1;
        end
    end

    assign error = error_r;
`else
    assign error = 1'b0;
`endif

    assign config_addr   = config_addr_r;
    assign config_data   = config_data_r;
    assign bit_ready     = bit_ready_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign words_written = ww_r;

endmodule
